// File: rtl/ps2_key_pkg.sv
// Shared scan-code constants, command and prefix-state types for the PS/2 arrow-key controller.
package ps2_key_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;

  typedef enum logic [1:0] {
    CMD_LEFT  = 2'd0,
    CMD_RIGHT = 2'd1,
    CMD_DOWN  = 2'd2,
    CMD_UP    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    PFX_IDLE = 2'd0,
    PFX_E0   = 2'd1,
    PFX_F0   = 2'd2,
    PFX_E0F0 = 2'd3
  } prefix_e;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SC_LEFT) || (code == SC_RIGHT) || (code == SC_DOWN) || (code == SC_UP);
  endfunction

  function automatic cmd_e arrow_cmd(input logic [7:0] code);
    cmd_e c;
    case (code)
      SC_RIGHT: c = CMD_RIGHT;
      SC_DOWN:  c = CMD_DOWN;
      SC_UP:    c = CMD_UP;
      default:  c = CMD_LEFT;
    endcase
    return c;
  endfunction

  // Counter width able to hold the larger of the two repeat intervals.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/ps2_repeat_timer.sv
// Auto-repeat interval timer: delay after a make, then a fixed period; one-cycle fire pulse.
// Built only when PS2_KEY_AUTOREPEAT_EN is defined.
`ifdef PS2_KEY_AUTOREPEAT_EN
module ps2_repeat_timer
  import ps2_key_pkg::*;
#(
  parameter int unsigned DELAY  = 25_000_000,
  parameter int unsigned PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_delay,
  input  logic stop,
  output logic fire
);

  localparam int unsigned CNT_W = timer_width(DELAY, PERIOD);

  logic [CNT_W-1:0] count;
  logic             active;

  // fire is registered, so reload values sit one below the interval to land the
  // consumer-visible command exactly DELAY / PERIOD cycles apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      active <= 1'b0;
      fire   <= 1'b0;
    end else begin
      fire <= 1'b0;
      if (load_delay) begin
        active <= 1'b1;
        count  <= CNT_W'(DELAY - 2);
      end else if (stop) begin
        active <= 1'b0;
      end else if (active) begin
        if (count == '0) begin
          fire  <= 1'b1;
          count <= CNT_W'(PERIOD - 1);
        end else begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule
`endif

// File: rtl/ps2_key_controller.sv
// PS/2 arrow-key decoder: scan handshake, E0/F0 prefix FSM, held flags and a single-entry
// command register. Auto-repeat is built when PS2_KEY_AUTOREPEAT_EN is defined.
module ps2_key_controller
  import ps2_key_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       scan_ready,
  input  logic [7:0] scan_code,
  output logic       read,
  output logic [3:0] key_held,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       cmd_repeat,
  input  logic       cmd_ready,
  output logic       cmd_dropped
);

  logic [2:0] sync_q;
  logic [7:0] code_q;
  prefix_e    prefix;

  logic       is_final_c;
  logic       is_break_c;
  logic       key_hit_c;
  logic       make_c;
  logic       break_c;
  logic       rep_c;
  logic       gen_c;
  logic [1:0] kidx_c;
  logic [1:0] rep_key_c;

  // Synchronise scan_ready; read doubles as the captured-code valid strobe.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
      code_q <= '0;
      read   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], scan_ready};
      read   <= sync_q[1] & ~sync_q[2];
      if (sync_q[1] & ~sync_q[2]) code_q <= scan_code;
    end
  end

  always_comb begin
    is_final_c = read && (code_q != SC_E0) && (code_q != SC_F0);
    is_break_c = (prefix == PFX_F0) || (prefix == PFX_E0F0);
    kidx_c     = arrow_cmd(code_q);
    key_hit_c  = is_final_c && is_arrow(code_q);
    make_c     = key_hit_c && !is_break_c && !key_held[kidx_c];
    break_c    = key_hit_c && is_break_c && key_held[kidx_c];
    gen_c      = make_c || rep_c;
  end

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      prefix <= PFX_IDLE;
    end else if (read) begin
      if (code_q == SC_E0) begin
        prefix <= (prefix == PFX_F0 || prefix == PFX_E0F0) ? PFX_E0F0 : PFX_E0;
      end else if (code_q == SC_F0) begin
        prefix <= (prefix == PFX_E0 || prefix == PFX_E0F0) ? PFX_E0F0 : PFX_F0;
      end else begin
        prefix <= PFX_IDLE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      key_held <= '0;
    end else if (make_c) begin
      key_held[kidx_c] <= 1'b1;
    end else if (break_c) begin
      key_held[kidx_c] <= 1'b0;
    end
  end

`ifdef PS2_KEY_AUTOREPEAT_EN
  logic [1:0] rep_key_q;
  logic       fire;
  logic       stop_c;

  // Only the most recently made key repeats; releasing it silences repeat entirely.
  assign stop_c    = break_c && (kidx_c == rep_key_q);
  assign rep_c     = fire && key_held[rep_key_q];
  assign rep_key_c = rep_key_q;

  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      rep_key_q <= '0;
    end else if (make_c) begin
      rep_key_q <= kidx_c;
    end
  end

  ps2_repeat_timer #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_repeat_timer (
    .clk        (CLOCK_50),
    .rst_n      (RST),
    .load_delay (make_c),
    .stop       (stop_c),
    .fire       (fire)
  );
`else
  assign rep_c     = 1'b0;
  assign rep_key_c = 2'd0;

  // Keeps the repeat parameters referenced when no timer is built.
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_repeat_params_unused
  end
`endif

  // Single-entry command register; a make outranks a same-cycle repeat.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_repeat  <= 1'b0;
      cmd_dropped <= 1'b0;
    end else begin
      cmd_dropped <= 1'b0;
      if (gen_c) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid  <= 1'b1;
          cmd_code   <= make_c ? kidx_c : rep_key_c;
          cmd_repeat <= !make_c;
        end else begin
          cmd_dropped <= 1'b1;
        end
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
